// File: rtl/arcanoid_pkg.sv
// ---------------------------------------------------------------------------
// arcanoid_pkg
// Shared definitions for the arcanoid game controller slice.
//   - game state encoding (IDLE..OVER) as 3-bit constants
//   - default game tuning values used as parameter defaults by the top
//   - helper that decodes the "ball parked on paddle" states
// No ports (package).
// ---------------------------------------------------------------------------
package arcanoid_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SERVE = 3'd1;
  localparam logic [2:0] ST_PLAY  = 3'd2;
  localparam logic [2:0] ST_LOST  = 3'd3;
  localparam logic [2:0] ST_CLEAR = 3'd4;
  localparam logic [2:0] ST_OVER  = 3'd5;

  localparam int LIVES_INIT_DEF   = 3;
  localparam int BRICKS_TOTAL_DEF = 40;
  localparam int BRICK_PTS_DEF    = 10;
  localparam int SCORE_W_DEF      = 16;
  localparam int DELAY_FRAMES_DEF = 60;

  // The ball sits on the paddle whenever play is not actively running
  // but a game is in progress.
  function automatic logic is_hold_state(input logic [2:0] st);
    return (st == ST_SERVE) || (st == ST_LOST) || (st == ST_CLEAR);
  endfunction

endpackage

// File: rtl/arcanoid_frame_seq.sv
// ---------------------------------------------------------------------------
// arcanoid_frame_seq
// Per-frame update sequencer: detects the vblnk rising edge, issues one
// update request per frame while the game is in PLAY, and flags frames
// where the previous update had not completed.
// Ports:
//   pclk        in   pixel clock, rising edge
//   rst         in   synchronous active-high reset
//   vblnk       in   vertical blanking level
//   play        in   game is in PLAY (registered state from the top)
//   upd_done    in   one-cycle completion pulse from the update engines
//   clr_overrun in   clears the sticky overrun flag (new game)
//   frame_tick  out  one-cycle pulse, registered vblnk rising edge
//   upd_start   out  one-cycle update request, cycle after frame_tick
//   overrun     out  sticky: frame_tick arrived with an update outstanding
// ---------------------------------------------------------------------------
module arcanoid_frame_seq
  import arcanoid_pkg::*;
(
  input  logic pclk,
  input  logic rst,
  input  logic vblnk,
  input  logic play,
  input  logic upd_done,
  input  logic clr_overrun,
  output logic frame_tick,
  output logic upd_start,
  output logic overrun
);

  logic vblnk_d;
  logic outstanding;

  always_ff @(posedge pclk) begin
    if (rst) begin
      vblnk_d    <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      vblnk_d    <= vblnk;
      frame_tick <= vblnk & ~vblnk_d;
    end
  end

  // Outstanding is dropped whenever we are not in PLAY so that a late
  // upd_done after leaving PLAY has nothing to act on. A frame that finds
  // an update still outstanding is skipped and recorded in overrun.
  always_ff @(posedge pclk) begin
    if (rst) begin
      upd_start   <= 1'b0;
      outstanding <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      upd_start <= 1'b0;
      if (!play) begin
        outstanding <= 1'b0;
      end else if (frame_tick && !outstanding) begin
        upd_start   <= 1'b1;
        outstanding <= 1'b1;
      end else if (upd_done) begin
        outstanding <= 1'b0;
      end

      if (clr_overrun) begin
        overrun <= 1'b0;
      end else if (play && frame_tick && outstanding) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/arcanoid_game_ctrl.sv
// ---------------------------------------------------------------------------
// arcanoid_game_ctrl
// Top-level game controller: main game FSM, lives/score/brick counters and
// the LOST/CLEAR delay, plus the per-frame update sequencer.
// Ports:
//   pclk        in   pixel clock, rising edge
//   rst         in   synchronous active-high reset
//   vblnk       in   vertical blanking level
//   btn_start   in   start/serve button level (synchronized, debounced)
//   brick_hit   in   one-cycle pulse per destroyed brick
//   ball_lost   in   one-cycle pulse when the ball leaves the bottom edge
//   upd_done    in   one-cycle pulse from update engines
//   upd_start   out  one-cycle frame update request
//   frame_tick  out  one-cycle pulse on vblnk rising edge
//   ball_hold   out  ball parked on paddle (SERVE, LOST, CLEAR)
//   game_state  out  current state encoding (see arcanoid_pkg)
//   lives       out  lives remaining
//   score       out  saturating score
//   bricks_left out  bricks remaining in the level
//   overrun     out  sticky update overrun flag
// ---------------------------------------------------------------------------
module arcanoid_game_ctrl
  import arcanoid_pkg::*;
#(
  parameter int LIVES_INIT   = LIVES_INIT_DEF,
  parameter int BRICKS_TOTAL = BRICKS_TOTAL_DEF,
  parameter int BRICK_PTS    = BRICK_PTS_DEF,
  parameter int SCORE_W      = SCORE_W_DEF,
  parameter int DELAY_FRAMES = DELAY_FRAMES_DEF
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic               vblnk,
  input  logic               btn_start,
  input  logic               brick_hit,
  input  logic               ball_lost,
  input  logic               upd_done,
  output logic               upd_start,
  output logic               frame_tick,
  output logic               ball_hold,
  output logic [2:0]         game_state,
  output logic [2:0]         lives,
  output logic [SCORE_W-1:0] score,
  output logic [7:0]         bricks_left,
  output logic               overrun
);

  localparam logic [SCORE_W-1:0] SCORE_MAX   = '1;
  localparam logic [SCORE_W:0]   PTS_EXT     = (SCORE_W+1)'(BRICK_PTS);
  localparam logic [2:0]         LIVES_LOAD  = 3'(LIVES_INIT);
  localparam logic [7:0]         BRICKS_LOAD = 8'(BRICKS_TOTAL);
  localparam logic [7:0]         DELAY_LOAD  = 8'(DELAY_FRAMES);

  logic               btn_d;
  logic               btn_rise;
  logic               play;
  logic               clr_overrun;
  logic               last_brick;
  logic [7:0]         delay_cnt;
  logic [SCORE_W:0]   score_sum;
  logic [SCORE_W-1:0] score_next;

  assign btn_rise    = btn_start & ~btn_d;
  assign play        = (game_state == ST_PLAY);
  assign clr_overrun = (game_state == ST_IDLE) && btn_rise;
  assign last_brick  = (bricks_left == 8'd1);
  assign ball_hold   = is_hold_state(game_state);

  // One extra bit catches the carry so the score clamps at all-ones.
  assign score_sum  = {1'b0, score} + PTS_EXT;
  assign score_next = score_sum[SCORE_W] ? SCORE_MAX : score_sum[SCORE_W-1:0];

  arcanoid_frame_seq u_frame_seq (
    .pclk        (pclk),
    .rst         (rst),
    .vblnk       (vblnk),
    .play        (play),
    .upd_done    (upd_done),
    .clr_overrun (clr_overrun),
    .frame_tick  (frame_tick),
    .upd_start   (upd_start),
    .overrun     (overrun)
  );

  // Main game FSM. A hit that empties the level wins over a simultaneous
  // ball loss: the level is cleared and no life is taken.
  always_ff @(posedge pclk) begin
    if (rst) begin
      game_state  <= ST_IDLE;
      lives       <= 3'd0;
      score       <= '0;
      bricks_left <= 8'd0;
      delay_cnt   <= 8'd0;
      btn_d       <= 1'b0;
    end else begin
      btn_d <= btn_start;
      case (game_state)
        ST_IDLE: begin
          if (btn_rise) begin
            lives       <= LIVES_LOAD;
            score       <= '0;
            bricks_left <= BRICKS_LOAD;
            game_state  <= ST_SERVE;
          end
        end
        ST_SERVE: begin
          if (btn_rise) begin
            game_state <= ST_PLAY;
          end
        end
        ST_PLAY: begin
          if (brick_hit) begin
            score <= score_next;
            if (bricks_left != 8'd0) begin
              bricks_left <= bricks_left - 8'd1;
            end
          end
          if (brick_hit && last_brick) begin
            game_state <= ST_CLEAR;
            delay_cnt  <= DELAY_LOAD;
          end else if (ball_lost) begin
            if (lives != 3'd0) begin
              lives <= lives - 3'd1;
            end
            game_state <= (lives <= 3'd1) ? ST_OVER : ST_LOST;
            delay_cnt  <= DELAY_LOAD;
          end
        end
        ST_LOST, ST_CLEAR: begin
          if (delay_cnt == 8'd0) begin
            game_state <= ST_SERVE;
            if (game_state == ST_CLEAR) begin
              bricks_left <= BRICKS_LOAD;
            end
          end else if (frame_tick) begin
            delay_cnt <= delay_cnt - 8'd1;
          end
        end
        ST_OVER: begin
          if (btn_rise) begin
            game_state <= ST_IDLE;
          end
        end
        default: begin
          game_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arcanoid_game_ctrl.sv
// ---------------------------------------------------------------------------
// tb_arcanoid_game_ctrl
// Self-checking bench for arcanoid_game_ctrl. A cycle-level behavioural
// model of the game rules runs alongside the DUT and every output is
// compared on each falling edge; directed sequences add hand-computed
// literal checks at the interesting points of a game.
// ---------------------------------------------------------------------------
module tb_arcanoid_game_ctrl;

  localparam int LIVES     = 3;
  localparam int TOTAL     = 40;
  localparam int PTS       = 10;
  localparam int SW        = 9;
  localparam int DELAY     = 60;
  localparam int SCORE_TOP = (1 << SW) - 1;

  localparam int S_IDLE  = 0;
  localparam int S_SERVE = 1;
  localparam int S_PLAY  = 2;
  localparam int S_LOST  = 3;
  localparam int S_CLEAR = 4;
  localparam int S_OVER  = 5;

  logic          pclk = 1'b0;
  logic          rst = 1'b1;
  logic          vblnk = 1'b0;
  logic          btn_start = 1'b0;
  logic          brick_hit = 1'b0;
  logic          ball_lost = 1'b0;
  logic          upd_done = 1'b0;
  logic          upd_start;
  logic          frame_tick;
  logic          ball_hold;
  logic [2:0]    game_state;
  logic [2:0]    lives;
  logic [SW-1:0] score;
  logic [7:0]    bricks_left;
  logic          overrun;

  int n_compared = 0;
  int n_failed   = 0;
  bit check_en   = 1'b0;

  arcanoid_game_ctrl #(
    .LIVES_INIT   (LIVES),
    .BRICKS_TOTAL (TOTAL),
    .BRICK_PTS    (PTS),
    .SCORE_W      (SW),
    .DELAY_FRAMES (DELAY)
  ) dut (
    .pclk        (pclk),
    .rst         (rst),
    .vblnk       (vblnk),
    .btn_start   (btn_start),
    .brick_hit   (brick_hit),
    .ball_lost   (ball_lost),
    .upd_done    (upd_done),
    .upd_start   (upd_start),
    .frame_tick  (frame_tick),
    .ball_hold   (ball_hold),
    .game_state  (game_state),
    .lives       (lives),
    .score       (score),
    .bricks_left (bricks_left),
    .overrun     (overrun)
  );

  always #5 pclk = ~pclk;

  // Model state: what each output must be after the current clock edge.
  int m_state, m_lives, m_score, m_bricks, m_ticks_seen;
  bit m_tick, m_start, m_overrun, m_busy, m_vb_prev, m_btn_prev;

  // Behavioural model of the game rules, stepped once per rising edge from
  // the same inputs the DUT samples. The LOST/CLEAR delay is modelled as a
  // count of frame ticks seen since entering the state.
  always @(posedge pclk) begin : model
    bit rise, tick_old, busy_old, in_play;
    if (rst) begin
      m_state = S_IDLE; m_lives = 0; m_score = 0; m_bricks = 0;
      m_ticks_seen = 0; m_tick = 0; m_start = 0; m_overrun = 0;
      m_busy = 0; m_vb_prev = 0; m_btn_prev = 0;
    end else begin
      rise       = btn_start && !m_btn_prev;
      tick_old   = m_tick;
      busy_old   = m_busy;
      in_play    = (m_state == S_PLAY);
      m_btn_prev = btn_start;
      m_tick     = vblnk && !m_vb_prev;
      m_vb_prev  = vblnk;

      m_start = in_play && tick_old && !busy_old;
      if (!in_play) m_busy = 0;
      else if (m_start) m_busy = 1;
      else if (upd_done) m_busy = 0;
      if (in_play && tick_old && busy_old) m_overrun = 1;

      case (m_state)
        S_IDLE: if (rise) begin
          m_lives = LIVES; m_score = 0; m_bricks = TOTAL;
          m_overrun = 0; m_state = S_SERVE;
        end
        S_SERVE: if (rise) m_state = S_PLAY;
        S_PLAY: begin
          if (brick_hit) begin
            m_score  = (m_score + PTS > SCORE_TOP) ? SCORE_TOP : m_score + PTS;
            m_bricks = (m_bricks > 0) ? m_bricks - 1 : 0;
          end
          if (brick_hit && m_bricks == 0) begin
            m_state = S_CLEAR; m_ticks_seen = 0;
          end else if (ball_lost) begin
            m_state = (m_lives == 1) ? S_OVER : S_LOST;
            m_lives = m_lives - 1;
            m_ticks_seen = 0;
          end
        end
        S_LOST, S_CLEAR: begin
          if (m_ticks_seen == DELAY) begin
            if (m_state == S_CLEAR) m_bricks = TOTAL;
            m_state = S_SERVE;
          end else if (tick_old) begin
            m_ticks_seen++;
          end
        end
        S_OVER: if (rise) m_state = S_IDLE;
        default: m_state = S_IDLE;
      endcase
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_compared++;
    if (actual !== expected) begin
      n_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Continuous comparison of every output against the model.
  always @(negedge pclk) begin
    if (check_en) begin
      checkOutput("state",       int'(game_state),  m_state);
      checkOutput("lives",       int'(lives),       m_lives);
      checkOutput("score",       int'(score),       m_score);
      checkOutput("bricks_left", int'(bricks_left), m_bricks);
      checkOutput("frame_tick",  int'(frame_tick),  int'(m_tick));
      checkOutput("upd_start",   int'(upd_start),   int'(m_start));
      checkOutput("overrun",     int'(overrun),     int'(m_overrun));
      checkOutput("ball_hold",   int'(ball_hold),
                  int'(m_state == S_SERVE || m_state == S_LOST || m_state == S_CLEAR));
    end
  end

  // Drive one input vector and hold it for n cycles; returns 1 time unit
  // after the last rising edge so registered outputs are settled.
  task automatic applyStimulus(input bit b, input bit h, input bit l,
                               input bit d, input bit v, input int n);
    btn_start = b; brick_hit = h; ball_lost = l; upd_done = d; vblnk = v;
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic press();
    applyStimulus(1, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
  endtask

  task automatic hit();
    applyStimulus(0, 1, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
  endtask

  task automatic lose();
    applyStimulus(0, 0, 1, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
  endtask

  task automatic done_pulse();
    applyStimulus(0, 0, 0, 1, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      applyStimulus(0, 0, 0, 0, 1, 2);
      applyStimulus(0, 0, 0, 0, 0, 2);
    end
  endtask

  initial begin
    repeat (2) @(posedge pclk);
    #1;
    check_en = 1'b1;
    checkOutput("rst_state", int'(game_state), S_IDLE);
    checkOutput("rst_lives", int'(lives), 0);
    checkOutput("rst_score", int'(score), 0);
    checkOutput("rst_bricks", int'(bricks_left), 0);
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 1);

    // New game and serve
    press();
    checkOutput("serve_state", int'(game_state), S_SERVE);
    checkOutput("serve_hold", int'(ball_hold), 1);
    checkOutput("serve_lives", int'(lives), 3);
    checkOutput("serve_bricks", int'(bricks_left), 40);
    hit();
    checkOutput("hit_outside_play", int'(bricks_left), 40);
    press();
    checkOutput("play_state", int'(game_state), S_PLAY);
    checkOutput("play_hold", int'(ball_hold), 0);

    // Frame tick then update request, then an overrun frame
    applyStimulus(0, 0, 0, 0, 1, 1);
    checkOutput("tick_pulse", int'(frame_tick), 1);
    checkOutput("tick_no_start", int'(upd_start), 0);
    applyStimulus(0, 0, 0, 0, 1, 1);
    checkOutput("start_pulse", int'(upd_start), 1);
    applyStimulus(0, 0, 0, 0, 0, 2);
    applyStimulus(0, 0, 0, 0, 1, 2);
    checkOutput("overrun_set", int'(overrun), 1);
    checkOutput("overrun_no_start", int'(upd_start), 0);
    applyStimulus(0, 0, 0, 0, 0, 2);
    done_pulse();
    applyStimulus(0, 0, 0, 0, 1, 2);
    checkOutput("start_after_done", int'(upd_start), 1);
    applyStimulus(0, 0, 0, 0, 0, 2);
    done_pulse();

    // Clear the level
    repeat (40) hit();
    checkOutput("clear_score", int'(score), 400);
    checkOutput("clear_bricks", int'(bricks_left), 0);
    checkOutput("clear_state", int'(game_state), S_CLEAR);
    frames(60);
    applyStimulus(0, 0, 0, 0, 0, 2);
    checkOutput("clear_to_serve", int'(game_state), S_SERVE);
    checkOutput("clear_reload", int'(bricks_left), 40);
    checkOutput("clear_keep_score", int'(score), 400);

    // Lose all lives
    press(); lose();
    checkOutput("lost1_lives", int'(lives), 2);
    checkOutput("lost1_state", int'(game_state), S_LOST);
    frames(60); applyStimulus(0, 0, 0, 0, 0, 2);
    checkOutput("lost1_serve", int'(game_state), S_SERVE);
    press(); lose();
    checkOutput("lost2_lives", int'(lives), 1);
    frames(60); applyStimulus(0, 0, 0, 0, 0, 2);
    press(); lose();
    checkOutput("over_state", int'(game_state), S_OVER);
    checkOutput("over_lives", int'(lives), 0);
    press();
    checkOutput("over_to_idle", int'(game_state), S_IDLE);
    checkOutput("idle_keep_score", int'(score), 400);

    // Second game: last brick together with ball loss, then saturation
    press();
    checkOutput("ng_score", int'(score), 0);
    checkOutput("ng_overrun", int'(overrun), 0);
    press();
    repeat (39) hit();
    checkOutput("pre_last_bricks", int'(bricks_left), 1);
    applyStimulus(0, 1, 1, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("tie_state", int'(game_state), S_CLEAR);
    checkOutput("tie_lives", int'(lives), 3);
    checkOutput("tie_score", int'(score), 400);
    frames(60); applyStimulus(0, 0, 0, 0, 0, 2);
    press();
    repeat (11) hit();
    checkOutput("score_510", int'(score), 510);
    hit();
    checkOutput("score_sat", int'(score), 511);
    applyStimulus(0, 1, 1, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("tie2_state", int'(game_state), S_LOST);
    checkOutput("tie2_lives", int'(lives), 2);
    checkOutput("tie2_bricks", int'(bricks_left), 27);
    checkOutput("tie2_score", int'(score), 511);

    // Reset mid-game with an update outstanding
    frames(60); applyStimulus(0, 0, 0, 0, 0, 2);
    press();
    applyStimulus(0, 0, 0, 0, 1, 2);
    checkOutput("pre_rst_start", int'(upd_start), 1);
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 1);
    rst = 1'b0;
    checkOutput("mid_rst_state", int'(game_state), S_IDLE);
    checkOutput("mid_rst_lives", int'(lives), 0);
    checkOutput("mid_rst_score", int'(score), 0);
    checkOutput("mid_rst_start", int'(upd_start), 0);
    done_pulse();
    applyStimulus(0, 0, 0, 0, 0, 2);
    checkOutput("late_done_state", int'(game_state), S_IDLE);
    checkOutput("late_done_start", int'(upd_start), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule

// File: doc/arcanoid_game_ctrl.md
# arcanoid_game_ctrl

Frame-synchronous game controller for the arcanoid design. Sequences per-frame object updates (ball, paddle, bricks) during vertical blanking via a start/done handshake. Also tracks lives, score and remaining bricks, and drives the game state consumed by the draw pipeline ahead of the VGA output stage. Runs in the pixel clock domain (65 MHz, 1344x806 total frame).

## Interface
- LIVES_INIT, 3: lives loaded at new game (1..7)
- BRICKS_TOTAL, 40: bricks loaded per level (1..255)
- BRICK_PTS, 10: score added per brick hit
- SCORE_W, 16: score width
- DELAY_FRAMES, 60: frames spent in LOST/CLEAR before SERVE (1..255)

- pclk  in  1  pixel clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- vblnk  in  1  vertical blanking level from timing generator
- btn_start  in  1  start/serve button, already synchronized and debounced (level)
- brick_hit  in  1  one-cycle pulse per destroyed brick
- ball_lost  in  1  one-cycle pulse when ball leaves bottom edge
- upd_done  in  1  one-cycle pulse from update engines
- upd_start  out  1  one-cycle pulse requesting one frame update
- frame_tick  out  1  one-cycle pulse on vblnk rising edge
- ball_hold  out  1  ball parked on paddle (SERVE, LOST, CLEAR)
- game_state  out  3  current state encoding
- lives  out  3  lives remaining
- score  out  SCORE_W  current score, saturating
- bricks_left  out  8  bricks remaining
- overrun  out  1  sticky: update not done before next frame_tick

## Operation
- States: IDLE=0, SERVE=1, PLAY=2, LOST=3, CLEAR=4, OVER=5.
- Edge detect: frame_tick = vblnk & ~vblnk_d; btn_rise = btn_start & ~btn_d.
- IDLE: on btn_rise, load lives=LIVES_INIT, score=0, bricks_left=BRICKS_TOTAL, clear overrun, go SERVE.
- SERVE: ball_hold=1; on btn_rise go PLAY.
- PLAY: on each frame_tick, pulse upd_start if no update outstanding; otherwise set overrun and skip that frame. upd_done clears outstanding. upd_done while nothing outstanding is ignored.
- brick_hit in PLAY: score += BRICK_PTS, saturating at all-ones; bricks_left decrement (never below 0). Transition to CLEAR when bricks_left reaches 0.
- ball_lost in PLAY: lives decrement. Go OVER if lives was 1, else go LOST.
- Same-cycle brick_hit and ball_lost: score counted. If that hit empties bricks, go CLEAR and lives are not decremented; otherwise ball_lost is processed normally.
- brick_hit/ball_lost outside PLAY: ignored.
- LOST and CLEAR: a delay counter loads DELAY_FRAMES on entry and decrements on frame_tick. At 0, go SERVE. CLEAR also reloads bricks_left=BRICKS_TOTAL; score and lives are kept.
- OVER: hold score and lives; on btn_rise go IDLE.
- Leaving PLAY drops any outstanding update (outstanding cleared); a late upd_done is ignored.
- btn_rise and transitions are taken only on their own cycle; no queuing.

## Timing
- All outputs registered; one-cycle latency from input pulse to updated count/state.
- upd_start asserts on the cycle after the frame_tick detection cycle. frame_tick is itself one cycle after the vblnk rise (registered edge detect).
- Reset values: game_state=IDLE, lives=0, score=0, bricks_left=0, upd_start=0, frame_tick=0, ball_hold=0, overrun=0, delay counter=0, edge registers=0.
- Reset mid-game returns to IDLE within one cycle; the pending update is discarded.
- ball_hold is decoded from the registered state, so it changes on the same cycle as game_state.

## Structure
- Shared package arcanoid_pkg: state encoding constants, default LIVES_INIT/BRICKS_TOTAL/BRICK_PTS.
- Sub-module arcanoid_frame_seq: vblnk edge detect, upd_start/upd_done outstanding flag, overrun. The main FSM and counters stay in arcanoid_game_ctrl.

## Test plan
- Reset, then btn_start pulse twice → state IDLE→SERVE→PLAY; lives=3, score=0, bricks_left=40, ball_hold 1 then 0.
- PLAY, drive vblnk 0→1 → frame_tick one cycle later, upd_start the next cycle. If upd_done is withheld past the next vblnk rise → overrun=1 and no second upd_start.
- 40 brick_hit pulses → score=400, bricks_left=0, state CLEAR. After 60 frame_ticks → SERVE with bricks_left=40 and score=400.
- 3 ball_lost pulses across serves → lives 2, 1, then OVER with lives=0; btn_start → IDLE.
- Last brick_hit and ball_lost in the same cycle → CLEAR, lives unchanged, score +10. Score preloaded near 65535 → saturates at 65535.
- rst asserted in PLAY with an update outstanding → next cycle all outputs at reset values; a later upd_done causes no change.
